fetch_pc_unit: RTL and testbench

//  Program-counter and instruction-fetch sequencer for the multi-cycle RV32I core.

---
 rtl/rv32i_pkg.sv | 22 ++
 rtl/fetch_pc_unit_next_pc.sv | 28 ++
 rtl/fetch_pc_unit.sv | 109 ++++++++++
 tb/tb_fetch_pc_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: branch resolution encoding and fetch sequencer states.
package rv32i_pkg;

    // Branch resolution reported by the ALU at retire; encoding 2'b11 is unused.
    typedef enum logic [1:0] {
        BRANCH_NONE     = 2'd0,
        BRANCH_RELATIVE = 2'd1,
        BRANCH_ABSOLUTE = 2'd2
    } branch_type_e;

    // Fetch sequencer states; S_HALT is left only through reset.
    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// Next-PC selection for the fetch unit: sequential, PC-relative or absolute target,
// plus the 4-byte alignment check on the chosen target.
module next_pc_calc
    import rv32i_pkg::*;
(
    input  logic [31:0]  pc,
    input  branch_type_e branch_type,
    input  logic [31:0]  imm,
    input  logic [31:0]  alu_result,
    output logic [31:0]  next_pc,
    output logic         misaligned
);

    // Select the target; all sums wrap modulo 2^32.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives next_pc,
        // so no latch is inferred and the unused encoding falls back to sequential flow.
        next_pc = pc + PC_STEP;
        case (branch_type)
            BRANCH_RELATIVE: next_pc = pc + imm;
            BRANCH_ABSOLUTE: next_pc = alu_result;
            default:         ;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter and instruction-fetch sequencer: requests one word per instruction,
// hands it to the decoder, waits for retire, then advances the PC and instret.
module fetch_pc_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    input  logic         retire_valid,
    input  branch_type_e branch_type,
    input  logic [31:0]  alu_result,
    input  logic [31:0]  imm,
    output logic         misalign_err,
    output logic [63:0]  instret
);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  pc;
    logic [31:0]  calc_pc;
    logic         calc_misaligned;

    next_pc_calc u_next_pc_calc (
        .pc          (pc),
        .branch_type (branch_type),
        .imm         (imm),
        .alu_result  (alu_result),
        .next_pc     (calc_pc),
        .misaligned  (calc_misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (reset) state <= S_REQ;
        else       state <= state_next;
    end

    // Next-state logic and valids, decoded from the state register only.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) state_next = S_EXEC;
            end
            S_EXEC: begin
                if (retire_valid) state_next = calc_misaligned ? S_HALT : S_REQ;
            end
            S_HALT:  ;
            default: state_next = S_REQ;
        endcase
    end

    assign imem_req_addr = pc;

    // PC, captured instruction, error flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            inst         <= 32'd0;
            inst_pc      <= 32'd0;
            misalign_err <= 1'b0;
            instret      <= 64'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst    <= imem_rsp_data;
                        inst_pc <= pc;
                    end
                end
                S_EXEC: begin
                    if (retire_valid) begin
                        if (calc_misaligned) begin
                            // Keep the faulting instruction's PC for inspection.
                            misalign_err <= 1'b1;
                        end else begin
                            pc      <= calc_pc;
                            instret <= instret + 64'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a memory/decoder/execute environment runs on the
// falling edge, expected fetch addresses and instructions are queued as they become known.
module tb_fetch_pc_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        branch_type_e bt;
        logic [31:0]  imm;
        logic [31:0]  alu;
    } op_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } inst_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         retire_valid;
    branch_type_e branch_type;
    logic [31:0]  alu_result;
    logic [31:0]  imm;
    logic         misalign_err;
    logic [63:0]  instret;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .retire_valid   (retire_valid),
        .branch_type    (branch_type),
        .alu_result     (alu_result),
        .imm            (imm),
        .misalign_err   (misalign_err),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_addr_q[$];
    inst_t       exp_inst_q[$];
    op_t         ops[$];
    logic [63:0] exp_instret = 64'd0;
    int          req_stall = 0;
    int          issue_stall = 0;
    bit          hold_rsp = 1'b0;
    bit          in_wait = 1'b0;
    bit          idle = 1'b0;
    bit          halted = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic op_t mk(input branch_type_e b, input logic [31:0] i, input logic [31:0] a);
        op_t o;
        o.bt  = b;
        o.imm = i;
        o.alu = a;
        return o;
    endfunction

    // Environment: memory, decoder and execute stage, acting on the falling edge.
    initial begin
        bit          rsp_pending;
        bit          exec_pend;
        bit          exp_req;
        bit          exp_halt;
        bit          exp_issue;
        bit          stalling_req;
        logic [31:0] rsp_addr;
        logic [31:0] cur_pc;
        logic [31:0] nxt;
        op_t         op;
        inst_t       e;
        rsp_pending = 0; exec_pend = 0; exp_req = 0; exp_halt = 0; exp_issue = 0;
        stalling_req = 0; rsp_addr = '0; cur_pc = '0;
        forever begin
            @(negedge clk);
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
            inst_ready     = 1'b0;
            retire_valid   = 1'b0;
            branch_type    = BRANCH_NONE;
            imm            = 32'd0;
            alu_result     = 32'd0;
            if (reset) begin
                rsp_pending = 0; exec_pend = 0; exp_req = 0; exp_halt = 0;
                exp_issue = 0; stalling_req = 0; in_wait = 0;
            end else begin
                if (exp_req) begin
                    check("req_after_retire", {63'd0, imem_req_valid}, 64'd1);
                    check("instret", instret, exp_instret);
                    exp_req = 0;
                end
                if (exp_halt) begin
                    check("misalign_err", {63'd0, misalign_err}, 64'd1);
                    check("halt_req_valid", {63'd0, imem_req_valid}, 64'd0);
                    check("halt_inst_valid", {63'd0, inst_valid}, 64'd0);
                    check("halt_instret", instret, exp_instret);
                    exp_halt = 0;
                end
                if (exp_issue) begin
                    check("inst_valid_latency", {63'd0, inst_valid}, 64'd1);
                    exp_issue = 0;
                end
                if (rsp_pending) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(rsp_addr);
                    rsp_pending    = 0;
                    exp_issue      = 1;
                end
                if (exec_pend) begin
                    if (ops.size() > 0) begin
                        op = ops.pop_front();
                        retire_valid = 1'b1;
                        branch_type  = op.bt;
                        imm          = op.imm;
                        alu_result   = op.alu;
                        case (op.bt)
                            BRANCH_RELATIVE: nxt = cur_pc + op.imm;
                            BRANCH_ABSOLUTE: nxt = op.alu;
                            default:         nxt = cur_pc + 32'd4;
                        endcase
                        exec_pend = 0;
                        if (nxt[1:0] != 2'b00) begin
                            halted   = 1;
                            idle     = 1;
                            exp_halt = 1;
                        end else begin
                            exp_instret = exp_instret + 64'd1;
                            exp_addr_q.push_back(nxt);
                            exp_req = 1;
                        end
                    end else begin
                        idle = 1;
                    end
                end
                if (imem_req_valid) begin
                    if (exp_addr_q.size() == 0) begin
                        check("spurious_req", {63'd0, imem_req_valid}, 64'd0);
                    end else if (req_stall > 0) begin
                        check("stall_addr", {32'd0, imem_req_addr}, {32'd0, exp_addr_q[0]});
                        req_stall--;
                        stalling_req = 1;
                    end else begin
                        check("fetch_addr", {32'd0, imem_req_addr}, {32'd0, exp_addr_q.pop_front()});
                        imem_req_ready = 1'b1;
                        e.pc   = imem_req_addr;
                        e.word = mem_word(imem_req_addr);
                        exp_inst_q.push_back(e);
                        rsp_addr = imem_req_addr;
                        if (hold_rsp) in_wait = 1;
                        else          rsp_pending = 1;
                        stalling_req = 0;
                    end
                end else if (stalling_req) begin
                    check("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
                    stalling_req = 0;
                end
                if (inst_valid) begin
                    if (exp_inst_q.size() == 0) begin
                        check("spurious_inst", {63'd0, inst_valid}, 64'd0);
                    end else if (issue_stall > 0) begin
                        check("stall_inst", {32'd0, inst}, {32'd0, exp_inst_q[0].word});
                        check("stall_inst_pc", {32'd0, inst_pc}, {32'd0, exp_inst_q[0].pc});
                        check("stall_no_fetch", {63'd0, imem_req_valid}, 64'd0);
                        issue_stall--;
                        // Inputs that must be ignored outside their own states.
                        retire_valid   = 1'b1;
                        branch_type    = BRANCH_ABSOLUTE;
                        alu_result     = 32'hDEAD_0000;
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = 32'hBAD0_BAD0;
                    end else begin
                        e = exp_inst_q.pop_front();
                        check("inst", {32'd0, inst}, {32'd0, e.word});
                        check("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
                        inst_ready = 1'b1;
                        cur_pc     = e.pc;
                        exec_pend  = 1;
                    end
                end
            end
        end
    end

    task automatic do_reset(input int rs, input int is);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_inst_q.delete();
        ops.delete();
        exp_instret = 64'd0;
        halted      = 0;
        idle        = 0;
        hold_rsp    = 0;
        req_stall   = rs;
        issue_stall = is;
        exp_addr_q.push_back(RST_PC);
        reset = 1'b0;
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("rst_addr", {32'd0, imem_req_addr}, {32'd0, RST_PC});
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while (!idle && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {63'd0, idle}, 64'd1);
        check({tag, "_drained"}, exp_addr_q.size(), 64'd0);
    endtask

    // Test sequence.
    initial begin
        int n;
        // Sequential fetch from RESET_PC.
        do_reset(0, 0);
        repeat (3) ops.push_back(mk(BRANCH_NONE, 32'd0, 32'd0));
        wait_idle("s1_idle", 200);
        check("s1_instret", instret, 64'd3);

        // Memory not ready for 3 cycles, decoder stalls 4 cycles.
        do_reset(3, 4);
        ops.push_back(mk(BRANCH_NONE, 32'd0, 32'd0));
        wait_idle("s2_idle", 200);
        check("s2_instret", instret, 64'd1);

        // Relative, absolute, unused encoding, sequential.
        do_reset(0, 0);
        ops.push_back(mk(BRANCH_ABSOLUTE, 32'd0, 32'h0000_0200));
        ops.push_back(mk(BRANCH_RELATIVE, 32'hFFFF_FFF8, 32'd0));
        ops.push_back(mk(BRANCH_ABSOLUTE, 32'h0000_0123, 32'h0000_4000));
        ops.push_back(mk(branch_type_e'(2'b11), 32'h0000_0123, 32'h0000_7777));
        ops.push_back(mk(BRANCH_NONE, 32'h0000_0040, 32'h0000_0040));
        wait_idle("s4_idle", 400);
        check("s4_instret", instret, 64'd5);

        // Misaligned relative target halts the unit.
        do_reset(0, 0);
        ops.push_back(mk(BRANCH_RELATIVE, 32'h0000_0006, 32'd0));
        wait_idle("s5_idle", 200);
        repeat (10) @(posedge clk);
        #1;
        check("s5_err_sticky", {63'd0, misalign_err}, 64'd1);
        check("s5_instret", instret, 64'd0);
        check("s5_halted", {63'd0, halted}, 64'd1);
        do_reset(0, 0);
        ops.push_back(mk(BRANCH_NONE, 32'd0, 32'd0));
        wait_idle("s5_restart_idle", 200);
        check("s5_restart_instret", instret, 64'd1);

        // Reset during S_WAIT, then PC wrap.
        do_reset(0, 0);
        hold_rsp = 1;
        n = 0;
        while (!in_wait && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("s6_in_wait", {63'd0, in_wait}, 64'd1);
        do_reset(0, 0);
        ops.push_back(mk(BRANCH_ABSOLUTE, 32'd0, 32'hFFFF_FFFC));
        ops.push_back(mk(BRANCH_NONE, 32'd0, 32'd0));
        wait_idle("s6_idle", 200);
        check("s6_instret", instret, 64'd2);
        check("s6_wrap_pc", {32'd0, imem_req_addr}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
